apb_pad_ctrl_v2: RTL and testbench

APB_PAD_CTRL_V2 -- requirements
Module: apb_pad_ctrl_v2

---
 rtl/apb_pad_ctrl_v2.sv | 205 ++++++++++++++++++++
 tb/tb_apb_pad_ctrl_v2.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_pad_ctrl_v2.sv
// rtl/apb_pad_ctrl_v2.sv - APB pad configuration/mux register block with lock; optional macro APB_PAD_CTRL_AUTOINC_EN
module apb_pad_ctrl_v2 #(
  parameter int unsigned            APB_ADDR_WIDTH = 12,
  parameter int unsigned            N_IO           = 64,
  parameter int unsigned            NBIT_PADCFG    = 6,
  parameter int unsigned            NBIT_PADMUX    = 2,
  parameter logic [NBIT_PADCFG-1:0] PADCFG_RST     = '1
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]            PADDR,
  input  logic [31:0]                          PWDATA,
  input  logic                                 PWRITE,
  input  logic                                 PSEL,
  input  logic                                 PENABLE,
  output logic [31:0]                          PRDATA,
  output logic                                 PREADY,
  output logic                                 PSLVERR,
  output logic [N_IO-1:0][NBIT_PADCFG-1:0]     pad_cfg_o,
  output logic [N_IO-1:0][NBIT_PADMUX-1:0]     pad_mux_o,
  output logic                                 cfg_locked_o
);

  localparam int unsigned IDX_W     = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam logic [31:0] INFO_WORD = {16'(N_IO), 8'(NBIT_PADMUX), 8'(NBIT_PADCFG)};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [N_IO-1:0][NBIT_PADCFG-1:0] cfg_q;
  logic [N_IO-1:0][NBIT_PADMUX-1:0] mux_q;
  logic [IDX_W-1:0]                 index_q, index_d;
  logic                             lock_q;
  logic [31:0]                      prdata_q;
  logic                             pready_q;
  logic                             pslverr_q;

  logic [11:0] addr12;
  logic        unused_addr_lsbs;
  logic        fire;
  logic [8:0]  tgt;
  logic        pad_hit;
  logic        err;
  logic [31:0] rdata;
  logic        wr_index;
  logic        wr_lock;
  logic        wr_pad;
`ifdef APB_PAD_CTRL_AUTOINC_EN
  logic        data_sel;
`endif

  // Only the low 12 address bits are decoded; byte-lane bits are don't-care.
  assign addr12           = 12'(PADDR);
  assign unused_addr_lsbs = ^addr12[1:0];

  // A transfer is accepted only from IDLE; ACK and GAP ignore the bus.
  assign fire = (state_q == ST_IDLE) && PSEL && PENABLE;

  // Address decode, error classification, read mux and write strobes.
  always_comb begin
    tgt      = '0;
    pad_hit  = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    wr_index = 1'b0;
    wr_lock  = 1'b0;
    wr_pad   = 1'b0;
`ifdef APB_PAD_CTRL_AUTOINC_EN
    data_sel = 1'b0;
`endif
    if (addr12[11:10] == 2'b01) begin
      tgt = {1'b0, addr12[9:2]};
      if (tgt >= 9'(N_IO)) err = 1'b1;
      else                 pad_hit = 1'b1;
    end else if (addr12[11:4] == 8'h00) begin
      case (addr12[3:2])
        2'd0: begin
          if (PWRITE) err = 1'b1;
          else        rdata = INFO_WORD;
        end
        2'd1: begin
          if (PWRITE) begin
            // The whole written value is range-checked, not just the stored bits.
            if (PWDATA >= 32'(N_IO)) err = 1'b1;
            else                     wr_index = 1'b1;
          end else begin
            rdata = 32'(index_q);
          end
        end
        2'd2: begin
          tgt     = 9'(index_q);
          pad_hit = 1'b1;
`ifdef APB_PAD_CTRL_AUTOINC_EN
          data_sel = 1'b1;
`endif
        end
        default: begin
          if (PWRITE) wr_lock = PWDATA[0];
          else        rdata = {31'b0, lock_q};
        end
      endcase
    end else begin
      err = 1'b1;
    end
    if (pad_hit) begin
      if (PWRITE) begin
        if (lock_q) err = 1'b1;
        else        wr_pad = 1'b1;
      end else begin
        for (int i = 0; i < int'(N_IO); i++) begin
          if (tgt == 9'(i)) begin
            rdata[0 +: NBIT_PADMUX] = mux_q[i];
            rdata[8 +: NBIT_PADCFG] = cfg_q[i];
          end
        end
      end
    end
  end

  // Next INDEX: explicit writes, plus optional post-increment on clean DATA accesses.
  always_comb begin
    index_d = index_q;
    if (wr_index) index_d = PWDATA[IDX_W-1:0];
`ifdef APB_PAD_CTRL_AUTOINC_EN
    if (data_sel && !err) begin
      if (index_q == IDX_W'(N_IO - 1)) index_d = '0;
      else                             index_d = index_q + 1'b1;
    end
`endif
  end

  // FSM next state: IDLE -> ACK -> GAP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fire) state_d = ST_ACK;
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Bus response registers: loaded when leaving IDLE, error cleared entering GAP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else if (fire) begin
      pready_q  <= 1'b1;
      pslverr_q <= err;
      prdata_q  <= (!PWRITE && !err) ? rdata : 32'h0;
    end else begin
      pready_q <= 1'b0;
      if (state_q == ST_ACK) pslverr_q <= 1'b0;
    end
  end

  // Control registers: INDEX and the sticky LOCK bit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      index_q <= '0;
      lock_q  <= 1'b0;
    end else if (fire && !err) begin
      index_q <= index_d;
      if (wr_lock) lock_q <= 1'b1;
    end
  end

  // Per-pad storage; commits only on an accepted, non-errored pad write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(N_IO); i++) begin
        cfg_q[i] <= PADCFG_RST;
        mux_q[i] <= '0;
      end
    end else if (fire && wr_pad && !err) begin
      for (int i = 0; i < int'(N_IO); i++) begin
        if (tgt == 9'(i)) begin
          mux_q[i] <= PWDATA[0 +: NBIT_PADMUX];
          cfg_q[i] <= PWDATA[8 +: NBIT_PADCFG];
        end
      end
    end
  end

  assign PRDATA       = prdata_q;
  assign PREADY       = pready_q;
  assign PSLVERR      = pslverr_q;
  assign pad_cfg_o    = cfg_q;
  assign pad_mux_o    = mux_q;
  assign cfg_locked_o = lock_q;

endmodule

// File: tb/tb_apb_pad_ctrl_v2.sv
// tb/tb_apb_pad_ctrl_v2.sv - directed self-checking bench for apb_pad_ctrl_v2
module tb_apb_pad_ctrl_v2;

  localparam int N_IO = 64;

  logic                    HCLK;
  logic                    HRESETn;
  logic [11:0]             PADDR;
  logic [31:0]             PWDATA;
  logic                    PWRITE;
  logic                    PSEL;
  logic                    PENABLE;
  logic [31:0]             PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [N_IO-1:0][5:0]    pad_cfg;
  logic [N_IO-1:0][1:0]    pad_mux;
  logic                    cfg_locked;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_index;

  apb_pad_ctrl_v2 dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .pad_cfg_o    (pad_cfg),
    .pad_mux_o    (pad_mux),
    .cfg_locked_o (cfg_locked)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full APB transfer; also verifies PREADY lasts one cycle and GAP clears PSLVERR.
  task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    bit seen;
    seen  = 1'b0;
    rdata = '0;
    err   = 1'b0;
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wdata;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge HCLK); #1;
      if (PREADY) begin
        seen = 1'b1;
        break;
      end
    end
    check("pready_seen", {31'b0, seen}, 32'd1);
    rdata   = PRDATA;
    err     = PSLVERR;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(posedge HCLK); #1;
    check("pready_one_cycle", {31'b0, PREADY}, 32'd0);
    check("pslverr_gap", {31'b0, PSLVERR}, 32'd0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PWRITE  = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_locked", {31'b0, cfg_locked}, 32'd0);
    check("rst_cfg5", 32'(pad_cfg[5]), 32'h3F);
    check("rst_mux5", 32'(pad_mux[5]), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // INFO register
    apb_xfer(12'h000, 1'b0, 32'h0, rd, er);
    check("info_data", rd, 32'h0040_0206);
    check("info_err", {31'b0, er}, 32'd0);
    apb_xfer(12'h004, 1'b0, 32'h0, rd, er);
    check("index_rst", rd, 32'd0);

    // Direct pad write and readback
    apb_xfer(12'h404, 1'b1, 32'h0000_2A03, rd, er);
    check("pad1_wr_err", {31'b0, er}, 32'd0);
    check("pad1_cfg", 32'(pad_cfg[1]), 32'h2A);
    check("pad1_mux", 32'(pad_mux[1]), 32'h3);
    check("pad0_cfg", 32'(pad_cfg[0]), 32'h3F);
    check("pad0_mux", 32'(pad_mux[0]), 32'h0);
    check("pad2_cfg", 32'(pad_cfg[2]), 32'h3F);
    apb_xfer(12'h404, 1'b0, 32'h0, rd, er);
    check("pad1_rd", rd, 32'h0000_2A03);
    apb_xfer(12'h40C, 1'b1, 32'hFFFF_FFFF, rd, er);
    apb_xfer(12'h40C, 1'b0, 32'h0, rd, er);
    check("pad3_rd_masked", rd, 32'h0000_3F03);
    apb_xfer(12'h4FC, 1'b1, 32'h0000_1102, rd, er);
    check("pad63_direct_mux", 32'(pad_mux[63]), 32'h2);

    // INDEX / DATA window
    apb_xfer(12'h004, 1'b1, 32'd63, rd, er);
    check("index_wr_err", {31'b0, er}, 32'd0);
    apb_xfer(12'h004, 1'b0, 32'h0, rd, er);
    check("index_rd63", rd, 32'd63);
    apb_xfer(12'h008, 1'b1, 32'h0000_0101, rd, er);
    apb_xfer(12'h008, 1'b1, 32'h0000_0202, rd, er);
`ifdef APB_PAD_CTRL_AUTOINC_EN
    check("data_pad63_mux", 32'(pad_mux[63]), 32'h1);
    check("data_pad63_cfg", 32'(pad_cfg[63]), 32'h1);
    check("data_pad0_mux", 32'(pad_mux[0]), 32'h2);
    exp_index = 32'd1;
`else
    check("data_pad63_mux", 32'(pad_mux[63]), 32'h2);
    check("data_pad63_cfg", 32'(pad_cfg[63]), 32'h2);
    check("data_pad0_mux", 32'(pad_mux[0]), 32'h0);
    exp_index = 32'd63;
`endif
    apb_xfer(12'h004, 1'b0, 32'h0, rd, er);
    check("index_after_data", rd, exp_index);

    // Error cases
    apb_xfer(12'h500, 1'b0, 32'h0, rd, er);
    check("pad64_err", {31'b0, er}, 32'd1);
    check("pad64_rdata", rd, 32'd0);
    apb_xfer(12'h010, 1'b0, 32'h0, rd, er);
    check("unmapped_err", {31'b0, er}, 32'd1);
    check("unmapped_rdata", rd, 32'd0);
    apb_xfer(12'h004, 1'b1, 32'd64, rd, er);
    check("index64_err", {31'b0, er}, 32'd1);
    apb_xfer(12'h004, 1'b0, 32'h0, rd, er);
    check("index_unchanged", rd, exp_index);
    apb_xfer(12'h000, 1'b1, 32'h1234_5678, rd, er);
    check("info_wr_err", {31'b0, er}, 32'd1);

    // Lock
    apb_xfer(12'h00C, 1'b1, 32'd1, rd, er);
    check("lock_wr_err", {31'b0, er}, 32'd0);
    check("locked_set", {31'b0, cfg_locked}, 32'd1);
    apb_xfer(12'h408, 1'b1, 32'h0000_1501, rd, er);
    check("locked_wr_err", {31'b0, er}, 32'd1);
    check("pad2_cfg_locked", 32'(pad_cfg[2]), 32'h3F);
    check("pad2_mux_locked", 32'(pad_mux[2]), 32'h0);
    apb_xfer(12'h008, 1'b1, 32'h0000_0303, rd, er);
    check("locked_data_err", {31'b0, er}, 32'd1);
    apb_xfer(12'h004, 1'b0, 32'h0, rd, er);
    check("index_locked_data", rd, exp_index);
    apb_xfer(12'h00C, 1'b1, 32'd0, rd, er);
    check("unlock_err", {31'b0, er}, 32'd0);
    check("locked_sticky", {31'b0, cfg_locked}, 32'd1);
    apb_xfer(12'h00C, 1'b0, 32'h0, rd, er);
    check("lock_rd", rd, 32'd1);

    // Reset during the ACK cycle of a write
    PADDR   = 12'h414;
    PWRITE  = 1'b1;
    PWDATA  = 32'h0000_1503;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    check("ack_before_rst", {31'b0, PREADY}, 32'd1);
    HRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    #1;
    check("rst_ack_pready", {31'b0, PREADY}, 32'd0);
    check("rst_ack_cfg5", 32'(pad_cfg[5]), 32'h3F);
    check("rst_ack_mux5", 32'(pad_mux[5]), 32'h0);
    check("rst_ack_cfg1", 32'(pad_cfg[1]), 32'h3F);
    check("rst_ack_locked", {31'b0, cfg_locked}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    check("post_rst_idle", {31'b0, PREADY}, 32'd0);
    apb_xfer(12'h404, 1'b0, 32'h0, rd, er);
    check("post_rst_pad1", rd, 32'h0000_3F00);
    apb_xfer(12'h414, 1'b1, 32'h0000_1503, rd, er);
    check("post_rst_wr_err", {31'b0, er}, 32'd0);
    check("post_rst_cfg5", 32'(pad_cfg[5]), 32'h15);
    check("post_rst_mux5", 32'(pad_mux[5]), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
